// File: rtl/msg_ser_pkg.sv
// Shared types and default sizing for the message serializer.
package msg_ser_pkg;

  localparam int MSG_W_DEF = 5;
  localparam int PL_W_DEF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_HOLD  = 2'd3
  } ser_state_t;

endpackage

// File: rtl/bit_timer.sv
// Reloadable down-counter: ticks while enabled at zero, then reloads i_val.
module bit_timer #(
  parameter int PL_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_en,
  input  logic [PL_W-1:0] i_val,
  output logic            o_tick
);

  logic [PL_W-1:0] r_cnt;
  logic            w_zero;

  assign w_zero = (r_cnt == {PL_W{1'b0}});
  assign o_tick = i_en & w_zero;

  // Count register: explicit load wins over free-running reload/decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= {PL_W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_en) begin
      if (w_zero) begin
        r_cnt <= i_val;
      end else begin
        r_cnt <= r_cnt - PL_W'(1);
      end
    end
  end

endmodule

// File: rtl/msg_serializer.sv
// Serializes MSG_W-bit messages MSB first, each bit held pl_q+1 cycles,
// in single-shot or repeat-with-gap mode.
module msg_serializer
  import msg_ser_pkg::*;
#(
  parameter int MSG_W = MSG_W_DEF,
  parameter int PL_W  = PL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [PL_W-1:0]  PL,
  input  logic             Mode,
  input  logic [MSG_W-1:0] Msg,
  input  logic             send,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int BCW = $clog2(MSG_W);

  ser_state_t       r_state;
  ser_state_t       w_state_nxt;
  logic [PL_W-1:0]  r_pl_q;
  logic             r_mode_q;
  logic [MSG_W-1:0] r_shift;
  logic [BCW-1:0]   r_bit_cnt;

  logic             w_cfg_load;
  logic [PL_W-1:0]  w_pl_eff;
  logic             w_tick;
  logic             w_tmr_load;
  logic             w_tmr_en;
  logic             w_last;
  logic             w_load_msg;
  logic             w_shift_en;

  // A config strobe coinciding with send must already time the new frame.
  assign w_cfg_load = (r_state == ST_IDLE) & init;
  assign w_pl_eff   = w_cfg_load ? PL : r_pl_q;
  assign w_tmr_load = (r_state == ST_IDLE) & send;
  assign w_tmr_en   = (r_state == ST_SHIFT) | (r_state == ST_GAP);
  assign w_last     = (r_bit_cnt == {BCW{1'b0}});

  bit_timer #(.PL_W(PL_W)) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_tmr_load),
    .i_en   (w_tmr_en),
    .i_val  (w_pl_eff),
    .o_tick (w_tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load_msg  = 1'b0;
    w_shift_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (send) begin
          w_state_nxt = ST_SHIFT;
          w_load_msg  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_tick && w_last) begin
          w_state_nxt = r_mode_q ? ST_GAP : ST_HOLD;
        end else if (w_tick) begin
          w_shift_en = 1'b1;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_GAP: begin
        if (w_tick && send) begin
          w_state_nxt = ST_SHIFT;
          w_load_msg  = 1'b1;
        end else if (w_tick) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_GAP;
        end
      end
      ST_HOLD: begin
        if (!send) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode; done marks the final cycle of a completed sequence.
  always_comb begin
    out  = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_SHIFT: begin
        out  = r_shift[MSG_W-1];
        busy = 1'b1;
        done = w_tick & w_last & ~r_mode_q;
      end
      ST_GAP: begin
        busy = 1'b1;
        done = w_tick & ~send;
      end
      ST_HOLD: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Configuration latch, open only while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pl_q   <= {PL_W{1'b0}};
      r_mode_q <= 1'b0;
    end else if (w_cfg_load) begin
      r_pl_q   <= PL;
      r_mode_q <= Mode;
    end
  end

  // Shift register and remaining-bit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift   <= {MSG_W{1'b0}};
      r_bit_cnt <= {BCW{1'b0}};
    end else if (w_load_msg) begin
      r_shift   <= Msg;
      r_bit_cnt <= BCW'(MSG_W - 1);
    end else if (w_shift_en) begin
      r_shift   <= {r_shift[MSG_W-2:0], 1'b0};
      r_bit_cnt <= r_bit_cnt - BCW'(1);
    end
  end

endmodule

// File: tb/tb_msg_serializer.sv
// Directed bench for msg_serializer (MSG_W=5, PL_W=3).
module tb_msg_serializer;

  logic       clk;
  logic       rst;
  logic       init;
  logic [2:0] PL;
  logic       Mode;
  logic [4:0] Msg;
  logic       send;
  logic       out;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;
  int nd;
  int da;

  msg_serializer #(.MSG_W(5), .PL_W(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .init (init),
    .PL   (PL),
    .Mode (Mode),
    .Msg  (Msg),
    .send (send),
    .out  (out),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_like(input string tag, input logic exp_busy, input logic exp_done);
    chk({tag, "_out"}, 32'(out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
  endtask

  // Called in the first bit cycle; returns after ticking past the last bit.
  task automatic check_frame(input logic [4:0] m, input int pl, input string tag,
                             input int chg_at, input logic [4:0] chg_msg, input int drop_at,
                             output int n_done, output int done_at);
    int bit_i;
    n_done  = 0;
    done_at = -1;
    for (int c = 0; c < 5 * (pl + 1); c++) begin
      bit_i = 4 - c / (pl + 1);
      chk({tag, "_out"}, 32'(out), 32'(m[bit_i]));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (done) begin
        n_done++;
        done_at = c;
      end
      if (c == chg_at) Msg = chg_msg;
      if (c == drop_at) send = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; PL = 3'd0; Mode = 1'b0; Msg = 5'd0; send = 1'b0;
    #2 rst = 1'b0;
    #1 chk_idle_like("reset", 1'b0, 1'b0);
    tick();
    rst = 1'b1;

    // Single-shot, one cycle per bit, send held for three edges.
    init = 1'b1; PL = 3'd0; Mode = 1'b0;
    tick();
    init = 1'b0; Msg = 5'b11011; send = 1'b1;
    tick();
    check_frame(5'b11011, 0, "t1", -1, 5'd0, 2, nd, da);
    chk("t1_ndone", 32'(nd), 32'd1);
    chk("t1_done_at", 32'(da), 32'd4);
    chk_idle_like("t1_hold", 1'b1, 1'b0);
    tick();
    chk_idle_like("t1_idle", 1'b0, 1'b0);
    tick(); tick(); tick();
    chk_idle_like("t1_no_second", 1'b0, 1'b0);

    // Three cycles per bit; HOLD persists while send stays high.
    init = 1'b1; PL = 3'b010; Mode = 1'b0;
    tick();
    init = 1'b0; send = 1'b1;
    tick();
    check_frame(5'b11011, 2, "t2", -1, 5'd0, -1, nd, da);
    chk("t2_ndone", 32'(nd), 32'd1);
    chk("t2_done_at", 32'(da), 32'd14);
    chk_idle_like("t2_hold0", 1'b1, 1'b0);
    tick();
    chk_idle_like("t2_hold1", 1'b1, 1'b0);
    send = 1'b0;
    tick();
    chk_idle_like("t2_idle", 1'b0, 1'b0);

    // Repeat mode with gap; Msg changed mid-frame only affects the next frame.
    init = 1'b1; PL = 3'd1; Mode = 1'b1;
    tick();
    init = 1'b0; Msg = 5'b11011; send = 1'b1;
    tick();
    check_frame(5'b11011, 1, "t3a", 3, 5'b00110, -1, nd, da);
    chk("t3a_ndone", 32'(nd), 32'd0);
    chk_idle_like("t3a_gap0", 1'b1, 1'b0);
    tick();
    chk_idle_like("t3a_gap1", 1'b1, 1'b0);
    tick();
    check_frame(5'b00110, 1, "t3b", -1, 5'd0, -1, nd, da);
    chk("t3b_ndone", 32'(nd), 32'd0);
    chk_idle_like("t3b_gap0", 1'b1, 1'b0);
    tick();
    chk_idle_like("t3b_gap1", 1'b1, 1'b0);
    tick();

    // send dropped during the second bit: frame and gap complete, one done.
    check_frame(5'b00110, 1, "t4", -1, 5'd0, 2, nd, da);
    chk("t4_ndone", 32'(nd), 32'd0);
    chk_idle_like("t4_gap0", 1'b1, 1'b0);
    tick();
    chk_idle_like("t4_gap1", 1'b1, 1'b1);
    tick();
    chk_idle_like("t4_idle", 1'b0, 1'b0);

    // init while busy is ignored; the following frame keeps PL=1.
    init = 1'b1; PL = 3'd1; Mode = 1'b0;
    tick();
    init = 1'b0; Msg = 5'b10110; send = 1'b1;
    tick();
    init = 1'b1; PL = 3'd7;
    check_frame(5'b10110, 1, "t5", -1, 5'd0, 4, nd, da);
    chk("t5_ndone", 32'(nd), 32'd1);
    chk("t5_done_at", 32'(da), 32'd9);
    init = 1'b0;
    tick();
    chk_idle_like("t5_idle", 1'b0, 1'b0);
    send = 1'b1;
    tick();
    chk("t5b_out0", 32'(out), 32'd1);
    tick();
    chk("t5b_out1", 32'(out), 32'd1);
    tick();
    chk("t5b_out2", 32'(out), 32'd0);
    tick();

    // Asynchronous reset mid-frame, between edges.
    #2 rst = 1'b0;
    #1 chk_idle_like("t6_rst_now", 1'b0, 1'b0);
    tick();
    chk_idle_like("t6_rst_edge", 1'b0, 1'b0);
    rst = 1'b1; Msg = 5'b10101;
    tick();
    check_frame(5'b10101, 0, "t6", -1, 5'd0, 0, nd, da);
    chk("t6_ndone", 32'(nd), 32'd1);
    chk("t6_done_at", 32'(da), 32'd4);
    chk_idle_like("t6_hold", 1'b1, 1'b0);
    tick();
    chk_idle_like("t6_idle", 1'b0, 1'b0);

    // Longest bit period; init together with send applies to this frame.
    init = 1'b1; PL = 3'b111; Mode = 1'b0; Msg = 5'b01101; send = 1'b1;
    tick();
    init = 1'b0;
    check_frame(5'b01101, 7, "t7", -1, 5'd0, 5, nd, da);
    chk("t7_ndone", 32'(nd), 32'd1);
    chk("t7_done_at", 32'(da), 32'd39);
    chk_idle_like("t7_hold", 1'b1, 1'b0);
    tick();
    chk_idle_like("t7_idle", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/msg_serializer.md
MSG_SERIALIZER -- requirements
Module: msg_serializer

Interface
REQ-001 Parameter MSG_W, default 5: message width in bits, legal 2..32.
REQ-002 Parameter PL_W, default 3: pulse-length field width, legal 1..16.
REQ-003 clk  input  1  single clock, rising-edge active.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 init  input  1  config load strobe, sampled in IDLE only.
REQ-006 PL  input  PL_W  bit period minus one, in clk cycles.
REQ-007 Mode  input  1  0 = single-shot, 1 = repeat while send held.
REQ-008 Msg  input  MSG_W  message, transmitted MSB first.
REQ-009 send  input  1  transmit request, level-sensitive.
REQ-010 out  output  1  serial line.
REQ-011 busy  output  1  high in SHIFT, GAP and HOLD.
REQ-012 done  output  1  one-cycle pulse at end of the last frame.

Function
REQ-013 States SHALL be IDLE, SHIFT, GAP and HOLD.
REQ-014 IDLE with init=1 SHALL latch PL into pl_q and Mode into mode_q at the clock edge.
REQ-015 init while busy=1 SHALL be ignored.
REQ-016 IDLE with send=1 SHALL load Msg into a shift register and SHALL set bit_cnt=MSG_W-1 and tick_cnt=pl_q, then go to SHIFT.
REQ-017 If init and send are both high in IDLE, the config SHALL be latched first and used for that same frame.
REQ-018 In SHIFT, out SHALL equal the shift-register MSB, and each bit SHALL be held for exactly pl_q+1 cycles.
REQ-019 In SHIFT, tick_cnt SHALL decrement each cycle; at 0 it SHALL reload pl_q, shift left and decrement bit_cnt.
REQ-020 The first bit SHALL appear on out in the cycle after the edge that sampled send=1 (latency 1).
REQ-021 A frame SHALL last MSG_W*(pl_q+1) cycles; pl_q=0 gives 1 cycle per bit, pl_q=2^PL_W-1 gives 2^PL_W cycles per bit.
REQ-022 After the last bit with mode_q=1, the block SHALL enter GAP: out=0 for pl_q+1 cycles.
REQ-023 At the end of GAP with send=1, the block SHALL reload the current Msg and return to SHIFT with no extra idle cycle.
REQ-024 At the end of GAP with send=0, the block SHALL pulse done and go to IDLE.
REQ-025 After the last bit with mode_q=0, the block SHALL pulse done and enter HOLD.
REQ-026 HOLD SHALL return to IDLE only in the cycle after send is sampled low, so one send level yields exactly one frame.
REQ-027 Changes on Msg, PL and Mode during busy SHALL NOT affect the frame in flight.
REQ-028 send dropping mid-frame SHALL NOT truncate the frame.
REQ-029 out SHALL be 0 in IDLE, GAP and HOLD.
REQ-030 done SHALL be high for exactly one cycle per completed sequence and never while in IDLE.

Reset
REQ-031 rst=0 SHALL immediately force state=IDLE, out=0, busy=0, done=0, pl_q=0, mode_q=0, shift register=0 and counters=0, independent of clk.
REQ-032 Reset asserted mid-frame SHALL abort the frame without a done pulse.
REQ-033 After rst deasserts, the block SHALL accept send on the first clock edge.

Structure
REQ-034 Package msg_ser_pkg SHALL hold the state enum typedef and the default values of MSG_W and PL_W.
REQ-035 A sub-module bit_timer (PL_W-bit reloadable down-counter, tick-out at zero) SHALL generate bit and gap periods.
REQ-036 All other logic SHALL be in msg_serializer; no latches, and a single always_ff per register group.

Verification
REQ-037 MSG_W=5, PL_W=3; init with PL=0, Mode=0; Msg=5'b11011; send high 3 cycles -> out=1,1,0,1,1 on consecutive cycles, done pulse once, no second frame.
REQ-038 init with PL=3'b010, Mode=0; Msg=5'b11011 -> each bit held 3 cycles, busy before done lasts 15 cycles.
REQ-039 init with PL=1, Mode=1; send held; Msg changed to 5'b00110 mid-frame -> frame 11011, 2 cycles of out=0, then frame 00110, repeating until send is low.
REQ-040 Mode=1; send dropped during bit 2 -> frame completes, GAP runs, done pulses once, then IDLE with out=0.
REQ-041 rst driven low mid-frame between clock edges -> out, busy and done go to 0 immediately with no done pulse; init applied during busy (PL=7) is ignored, and the next frame uses the old PL.
REQ-042 PL=3'b111 -> each bit held 8 cycles, frame 40 cycles; init and send together in IDLE -> new PL used for that frame.
